psram_tester: RTL

Parametrised built-in self-test for the PSRAM path: fills a configurable address range through the RAM controller's mem/rw/ready handshake with a selectable data pattern, reads it back, counts mismatches and captures the first failing location. Sits between the top-level sequencer and the RAM controller, replacing the inline write/read test states. Supports repeated passes and run-time abort.

---
 rtl/psram_tester.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/psram_tester.sv
// Purpose: PSRAM built-in self-test. Writes a pattern over 0..ADDR_LAST, reads it back, counts mismatches.
// Latency: start->mem 2 cycles with initialized high; one access per ready pulse, back-to-back capable.
// Backpressure: the access request is held stable until ready; abort wins over every transition.
module psram_tester #(
    parameter int              AW        = 23,
    parameter int              DW        = 16,
    parameter int              EW        = 16,
    parameter logic [AW-1:0]   ADDR_LAST = {AW{1'b1}}
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [1:0]    mode_i,
    input  logic          loop_i,
    input  logic          abort_i,
    input  logic          initialized_i,
    input  logic          ready_i,
    input  logic [DW-1:0] data_out_i,
    output logic          mem_o,
    output logic          rw_o,
    output logic [AW-1:0] address_o,
    output logic [DW-1:0] data_in_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          fail_o,
    output logic [EW-1:0] errors_o,
    output logic [7:0]    pass_count_o,
    output logic [AW-1:0] first_addr_o,
    output logic [DW-1:0] first_data_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_INIT,
        S_WRITE,
        S_READ,
        S_DONE,
        S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic          loop_q, loop_d;
    logic          mem_q, mem_d;
    logic          rw_q, rw_d;
    logic [AW-1:0] address_q, address_d;
    logic [EW-1:0] errors_q, errors_d;
    logic [7:0]    pass_q, pass_d;
    logic [AW-1:0] first_addr_q, first_addr_d;
    logic [DW-1:0] first_data_q, first_data_d;

    logic [DW-1:0] pat;
    logic [EW-1:0] errors_sat;
    logic          mismatch;
    logic          at_last;

    // Expected word for an address; mode 3 flips between all-ones and all-zeros on pass parity.
    function automatic logic [DW-1:0] pattern_f(input logic [AW-1:0] a, input logic [1:0] m,
                                                input logic odd_pass);
        logic [DW-1:0] r;
        r = '0;
        case (m)
            2'd0: r = DW'(a);
            2'd1: r = ~DW'(a);
            2'd2: for (int i = 0; i < DW; i++) r[i] = a[0] ^ i[0];
            default: r = odd_pass ? '0 : '1;
        endcase
        return r;
    endfunction

    assign pat        = pattern_f(address_q, mode_q, pass_q[0]);
    assign mismatch   = (data_out_i != pat);
    assign errors_sat = (errors_q == {EW{1'b1}}) ? errors_q : errors_q + 1'b1;
    assign at_last    = (address_q == ADDR_LAST);

    // Next-state and register updates; abort overrides everything but preserves results.
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        loop_d       = loop_q;
        mem_d        = mem_q;
        rw_d         = rw_q;
        address_d    = address_q;
        errors_d     = errors_q;
        pass_d       = pass_q;
        first_addr_d = first_addr_q;
        first_data_d = first_data_q;
        if (abort_i) begin
            state_d = S_IDLE;
            mem_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start_i) begin
                        mode_d       = mode_i;
                        loop_d       = loop_i;
                        errors_d     = '0;
                        pass_d       = '0;
                        first_addr_d = '0;
                        first_data_d = '0;
                        address_d    = '0;
                        state_d      = S_WAIT_INIT;
                    end
                end
                S_WAIT_INIT: begin
                    if (initialized_i) begin
                        mem_d   = 1'b1;
                        rw_d    = 1'b0;
                        state_d = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (ready_i) begin
                        if (at_last) begin
                            address_d = '0;
                            rw_d      = 1'b1;
                            state_d   = S_READ;
                        end else begin
                            address_d = address_q + 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (ready_i) begin
                        if (mismatch) begin
                            errors_d = errors_sat;
                            if (errors_q == '0) begin
                                first_addr_d = address_q;
                                first_data_d = data_out_i;
                            end
                        end
                        if (at_last) begin
                            pass_d = pass_q + 8'd1;
                            // Pass verdict must include the compare made on this very edge.
                            if (errors_d != '0) begin
                                mem_d   = 1'b0;
                                state_d = S_FAIL;
                            end else if (loop_q) begin
                                address_d = '0;
                                rw_d      = 1'b0;
                                state_d   = S_WRITE;
                            end else begin
                                mem_d   = 1'b0;
                                state_d = S_DONE;
                            end
                        end else begin
                            address_d = address_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    mem_d   = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            mode_q       <= '0;
            loop_q       <= 1'b0;
            mem_q        <= 1'b0;
            rw_q         <= 1'b0;
            address_q    <= '0;
            errors_q     <= '0;
            pass_q       <= '0;
            first_addr_q <= '0;
            first_data_q <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            loop_q       <= loop_d;
            mem_q        <= mem_d;
            rw_q         <= rw_d;
            address_q    <= address_d;
            errors_q     <= errors_d;
            pass_q       <= pass_d;
            first_addr_q <= first_addr_d;
            first_data_q <= first_data_d;
        end
    end

    assign mem_o        = mem_q;
    assign rw_o         = rw_q;
    assign address_o    = address_q;
    assign data_in_o    = pat;
    assign busy_o       = (state_q == S_WAIT_INIT) || (state_q == S_WRITE) || (state_q == S_READ);
    assign done_o       = (state_q == S_DONE);
    assign fail_o       = (state_q == S_FAIL);
    assign errors_o     = errors_q;
    assign pass_count_o = pass_q;
    assign first_addr_o = first_addr_q;
    assign first_data_o = first_data_q;

endmodule
